// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave.
//   DATA_W      : frame width in bits (MSB first)
//   SYNC_STAGES : flops in each input synchronizer chain
//   state_t     : FSM encoding; IDLE while synchronized ss is high, ACTIVE while it is low
package spi_pkg;

   localparam int DATA_W      = 8;
   localparam int SYNC_STAGES = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/spi_sync.sv
// One asynchronous input brought into the clk domain plus edge detection.
//   clk, rst  : system clock, synchronous active-high reset
//   async_in  : pin from the SPI bus (asynchronous to clk)
//   sync_out  : level after SYNC_STAGES flops
//   rise/fall : single-cycle pulses, registered one cycle after the edge
//               becomes visible on sync_out
// RST_VAL is the idle-bus level, so reset never manufactures a fake edge.
module spi_sync
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, 8-bit frames, oversampled by clk.
//   ss, sck, mosi : SPI bus pins (asynchronous, synchronized internally)
//   miso          : registered serial output, 0 while idle
//   tx_data/load  : write a byte into the transmit holding register
//   tx_full       : holding register has a byte not yet sent
//   data_out      : last complete received byte, held until the next one
//   new_data      : one-cycle pulse when data_out updates
//   busy          : synchronized ss is low
// Handshake: tx_load is a fire-and-forget strobe; it is always accepted and
// overwrites any byte still held. The held byte moves into the shifter at
// ss assertion and at every byte boundary (sck fall with bit_ctr==0).
module spi_slave
   import spi_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ss,
   input  logic              sck,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_full,
   output logic [DATA_W-1:0] data_out,
   output logic              new_data,
   output logic              busy
);

   logic sync_ss, sync_sck, sync_mosi;
   logic sck_rise, sck_fall;
   logic ss_rise, ss_fall, mosi_rise, mosi_fall;

   spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
      .clk(clk), .rst(rst), .async_in(ss),
      .sync_out(sync_ss), .rise(ss_rise), .fall(ss_fall)
   );

   spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
      .clk(clk), .rst(rst), .async_in(sck),
      .sync_out(sync_sck), .rise(sck_rise), .fall(sck_fall)
   );

   spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .async_in(mosi),
      .sync_out(sync_mosi), .rise(mosi_rise), .fall(mosi_fall)
   );

   // Only the sck edges drive the FSM; ss is used as a level.
   logic unused_edges;
   assign unused_edges = &{1'b0, ss_rise, ss_fall, mosi_rise, mosi_fall, sync_sck};

   state_t            state, state_d;
   logic [DATA_W-1:0] tx_hold, tx_hold_d;
   logic              tx_full_d;
   logic [DATA_W-1:0] tx_shift, tx_shift_d;
   logic [DATA_W-1:0] rx_shift, rx_shift_d;
   logic [2:0]        bit_ctr, bit_ctr_d;
   logic              miso_d;
   logic [DATA_W-1:0] data_out_d;
   logic              new_data_d;
   logic [DATA_W-1:0] reload_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx_hold  <= '0;
         tx_full  <= 1'b0;
         tx_shift <= '0;
         rx_shift <= '0;
         bit_ctr  <= 3'd0;
         miso     <= 1'b0;
         data_out <= '0;
         new_data <= 1'b0;
      end else begin
         state    <= state_d;
         tx_hold  <= tx_hold_d;
         tx_full  <= tx_full_d;
         tx_shift <= tx_shift_d;
         rx_shift <= rx_shift_d;
         bit_ctr  <= bit_ctr_d;
         miso     <= miso_d;
         data_out <= data_out_d;
         new_data <= new_data_d;
      end
   end

   always_comb begin
      state_d    = state;
      tx_hold_d  = tx_hold;
      tx_full_d  = tx_full;
      tx_shift_d = tx_shift;
      rx_shift_d = rx_shift;
      bit_ctr_d  = bit_ctr;
      miso_d     = miso;
      data_out_d = data_out;
      new_data_d = 1'b0;
      reload_val = tx_full ? tx_hold : '0;

      if (tx_load) begin
         tx_hold_d = tx_data;
         tx_full_d = 1'b1;
      end

      case (state)
         IDLE: begin
            miso_d = 1'b0;
            if (!sync_ss) begin
               state_d    = ACTIVE;
               tx_shift_d = reload_val;
               miso_d     = reload_val[DATA_W-1];
               bit_ctr_d  = 3'd0;
               // A load in the reload cycle stays held for the next byte.
               if (!tx_load) tx_full_d = 1'b0;
            end
         end
         ACTIVE: begin
            if (sync_ss) begin
               // Abort: partial byte is dropped, data_out untouched.
               state_d   = IDLE;
               bit_ctr_d = 3'd0;
               miso_d    = 1'b0;
            end else if (sck_rise) begin
               rx_shift_d = {rx_shift[DATA_W-2:0], sync_mosi};
               bit_ctr_d  = bit_ctr + 3'd1;
               if (bit_ctr == 3'd7) begin
                  data_out_d = {rx_shift[DATA_W-2:0], sync_mosi};
                  new_data_d = 1'b1;
               end
            end else if (sck_fall) begin
               if (bit_ctr == 3'd0) begin
                  tx_shift_d = reload_val;
                  miso_d     = reload_val[DATA_W-1];
                  if (!tx_load) tx_full_d = 1'b0;
               end else begin
                  tx_shift_d = {tx_shift[DATA_W-2:0], 1'b0};
                  miso_d     = tx_shift[DATA_W-2];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = ~sync_ss;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int HALF = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_full;
  logic [7:0] data_out;
  logic       new_data;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int nd_cnt   = 0;
  logic nd_prev = 1'b0;

  logic [7:0] exp_q[$];

  spi_slave dut (
    .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_full(tx_full),
    .data_out(data_out), .new_data(new_data), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every new_data pulse pops one expected received byte
  always @(negedge clk) begin
    if (new_data) begin
      nd_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rx_unexpected data_out=%02h expected=none", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL rx_byte data_out=%02h expected=%02h", data_out, e);
        end
      end
      checks++;
      if (nd_prev) begin
        failures++;
        $display("FAIL new_data_width pulse longer than one cycle");
      end
    end
    nd_prev <= new_data;
  end

  // driver tasks
  task automatic load_tx(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic ss_low();
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    ss   = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // master side: shifts nbits of mo out, returns what miso carried
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      repeat (HALF) @(negedge clk);
      mi  = {mi[6:0], miso};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_do);
    checks++;
    if (miso !== 1'b0) begin failures++; $display("FAIL %s_miso got=%b exp=0", tag, miso); end
    checks++;
    if (data_out !== exp_do) begin failures++; $display("FAIL %s_data_out got=%02h exp=%02h", tag, data_out, exp_do); end
    checks++;
    if (new_data !== 1'b0) begin failures++; $display("FAIL %s_new_data got=%b exp=0", tag, new_data); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy got=%b exp=0", tag, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 8'h00);
    checks++;
    if (tx_full !== 1'b0) begin failures++; $display("FAIL reset_tx_full got=%b exp=0", tx_full); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] mi;
    int n0;
    load_tx(8'hA5);
    checks++;
    if (tx_full !== 1'b1) begin failures++; $display("FAIL basic_tx_full_set got=%b exp=1", tx_full); end
    n0 = nd_cnt;
    exp_q.push_back(8'h3C);
    ss_low();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    checks++;
    if (tx_full !== 1'b0) begin failures++; $display("FAIL basic_tx_full_clr got=%b exp=0", tx_full); end
    spi_xfer(8'h3C, 8, mi);
    checks++;
    if (mi !== 8'hA5) begin failures++; $display("FAIL basic_miso got=%02h exp=a5", mi); end
    ss_high();
    checks++;
    if (nd_cnt - n0 != 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", nd_cnt - n0); end
    check_idle_outputs("basic_end", 8'h3C);
  endtask

  task automatic test_no_load();
    logic [7:0] mi;
    exp_q.push_back(8'hFF);
    ss_low();
    spi_xfer(8'hFF, 8, mi);
    checks++;
    if (mi !== 8'h00) begin failures++; $display("FAIL noload_miso got=%02h exp=00", mi); end
    ss_high();
    checks++;
    if (data_out !== 8'hFF) begin failures++; $display("FAIL noload_data_out got=%02h exp=ff", data_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m0, m1, m2;
    logic [7:0] next_tx[2];
    int n0, waited;
    next_tx[0] = 8'h5A;
    next_tx[1] = 8'h96;
    n0 = nd_cnt;
    load_tx(8'hC3);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h7E);
    ss_low();
    fork
      begin
        spi_xfer(8'h01, 8, m0);
        spi_xfer(8'h80, 8, m1);
        spi_xfer(8'h7E, 8, m2);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          waited = 0;
          while (!new_data && waited < 4000) begin
            @(negedge clk);
            waited++;
          end
          checks++;
          if (!new_data) begin
            failures++;
            $display("FAIL b2b_wait_new_data byte=%0d timed out", k);
          end else begin
            load_tx(next_tx[k]);
          end
        end
      end
    join
    ss_high();
    checks++;
    if (m0 !== 8'hC3) begin failures++; $display("FAIL b2b_miso0 got=%02h exp=c3", m0); end
    checks++;
    if (m1 !== 8'h5A) begin failures++; $display("FAIL b2b_miso1 got=%02h exp=5a", m1); end
    checks++;
    if (m2 !== 8'h96) begin failures++; $display("FAIL b2b_miso2 got=%02h exp=96", m2); end
    checks++;
    if (nd_cnt - n0 != 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", nd_cnt - n0); end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int n0;
    n0 = nd_cnt;
    ss_low();
    spi_xfer(8'hA0, 5, mi);
    ss_high();
    checks++;
    if (nd_cnt != n0) begin failures++; $display("FAIL abort_pulses got=%0d exp=0", nd_cnt - n0); end
    check_idle_outputs("abort", 8'h7E);
    exp_q.push_back(8'h99);
    ss_low();
    spi_xfer(8'h99, 8, mi);
    ss_high();
    checks++;
    if (data_out !== 8'h99) begin failures++; $display("FAIL abort_next_data_out got=%02h exp=99", data_out); end
    checks++;
    if (mi !== 8'h00) begin failures++; $display("FAIL abort_next_miso got=%02h exp=00", mi); end
  endtask

  task automatic test_overwrite();
    logic [7:0] mi;
    load_tx(8'h11);
    load_tx(8'h22);
    exp_q.push_back(8'h4D);
    ss_low();
    spi_xfer(8'h4D, 8, mi);
    ss_high();
    checks++;
    if (mi !== 8'h22) begin failures++; $display("FAIL overwrite_miso got=%02h exp=22", mi); end
    // load coincident with the ss reload: ss synchronizes after 2 edges,
    // FSM reloads on the third
    load_tx(8'h33);
    ss = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tx_data = 8'h44;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL coincide_busy got=%b exp=1", busy); end
    checks++;
    if (tx_full !== 1'b1) begin failures++; $display("FAIL coincide_tx_full got=%b exp=1", tx_full); end
    repeat (HALF) @(negedge clk);
    exp_q.push_back(8'hB2);
    spi_xfer(8'hB2, 8, mi);
    ss_high();
    checks++;
    if (mi !== 8'h33) begin failures++; $display("FAIL coincide_miso got=%02h exp=33", mi); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    load_tx(8'h77);
    ss_low();
    spi_xfer(8'hE0, 3, mi);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst", 8'h00);
    checks++;
    if (tx_full !== 1'b0) begin failures++; $display("FAIL midrst_tx_full got=%b exp=0", tx_full); end
    rst  = 1'b0;
    ss   = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
    exp_q.push_back(8'hC5);
    ss_low();
    spi_xfer(8'hC5, 8, mi);
    ss_high();
    checks++;
    if (mi !== 8'h00) begin failures++; $display("FAIL midrst_next_miso got=%02h exp=00", mi); end
    checks++;
    if (data_out !== 8'hC5) begin failures++; $display("FAIL midrst_next_data_out got=%02h exp=c5", data_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_load();
    test_back_to_back();
    test_abort();
    test_overwrite();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
